// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode and FSM encodings shared by the shift_reg_burst slice
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ASR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_HOLD6 = 3'b110,
        MODE_HOLD7 = 3'b111
    } shift_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    localparam shift_mode_e MODE_RESET  = MODE_HOLD;
    localparam burst_state_e STATE_RESET = ST_IDLE;

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - one-step next-value logic; rotate modes only when SHIFT_REG_ROTATE_EN is defined
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    input  shift_mode_e      i_mode,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_next,
    output logic             o_bit,
    output logic             o_shifted
);

    // o_shifted tells the caller whether the out bit is meaningful; holds keep the old sout
    always_comb begin
        o_next    = i_value;
        o_bit     = 1'b0;
        o_shifted = 1'b0;
        case (i_mode)
            MODE_SHL: begin
                o_next    = {i_value[WIDTH-2:0], i_sin};
                o_bit     = i_value[WIDTH-1];
                o_shifted = 1'b1;
            end
            MODE_SHR: begin
                o_next    = {i_sin, i_value[WIDTH-1:1]};
                o_bit     = i_value[0];
                o_shifted = 1'b1;
            end
            MODE_ASR: begin
                o_next    = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_bit     = i_value[0];
                o_shifted = 1'b1;
            end
`ifdef SHIFT_REG_ROTATE_EN
            MODE_ROTL: begin
                o_next    = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_bit     = i_value[WIDTH-1];
                o_shifted = 1'b1;
            end
            MODE_ROTR: begin
                o_next    = {i_value[0], i_value[WIDTH-1:1]};
                o_bit     = i_value[0];
                o_shifted = 1'b1;
            end
`endif
            default: begin
                o_next    = i_value;
                o_bit     = 1'b0;
                o_shifted = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_burst.sv
// rtl/shift_reg_burst.sv - universal shift register with counted burst engine; rotate via SHIFT_REG_ROTATE_EN
module shift_reg_burst
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       sel,
    input  logic             en,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shiftreg,
    output logic             sout
);

    burst_state_e     r_state;
    shift_mode_e      r_mode;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_shiftreg;
    logic             r_sout;
    logic             r_done;

    burst_state_e     w_next_state;
    shift_mode_e      w_next_mode;
    logic [CNT_W-1:0] w_next_rem;
    logic [WIDTH-1:0] w_next_reg;
    logic             w_next_sout;
    logic             w_next_done;

    shift_mode_e      w_step_mode;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_bit;
    logic             w_step_shifted;

    // One step unit serves both paths: latched mode while bursting, live sel while idle
    assign w_step_mode = (r_state == ST_BURST) ? r_mode : shift_mode_e'(sel);

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .i_value   (r_shiftreg),
        .i_mode    (w_step_mode),
        .i_sin     (sin),
        .o_next    (w_step_value),
        .o_bit     (w_step_bit),
        .o_shifted (w_step_shifted)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_mode  = r_mode;
        w_next_rem   = r_rem;
        w_next_reg   = r_shiftreg;
        w_next_sout  = r_sout;
        w_next_done  = 1'b0;
        if (load) begin
            w_next_reg   = data;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_mode  = shift_mode_e'(sel);
                        w_next_rem   = count;
                        w_next_state = ST_BURST;
                    end else if (en && w_step_shifted) begin
                        w_next_reg  = w_step_value;
                        w_next_sout = w_step_bit;
                    end
                end
                ST_BURST: begin
                    if (r_rem != '0) begin
                        if (w_step_shifted) begin
                            w_next_reg  = w_step_value;
                            w_next_sout = w_step_bit;
                        end
                        w_next_rem = r_rem - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_done  = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= STATE_RESET;
            r_mode     <= MODE_RESET;
            r_rem      <= '0;
            r_shiftreg <= '0;
            r_sout     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mode     <= w_next_mode;
            r_rem      <= w_next_rem;
            r_shiftreg <= w_next_reg;
            r_sout     <= w_next_sout;
            r_done     <= w_next_done;
        end
    end

    assign busy     = (r_state == ST_BURST);
    assign done     = r_done;
    assign shiftreg = r_shiftreg;
    assign sout     = r_sout;

endmodule

// File: tb/tb_shift_reg_burst.sv
// tb/tb_shift_reg_burst.sv - directed self-checking bench for shift_reg_burst (WIDTH=16)
module tb_shift_reg_burst;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [2:0]  sel;
    logic        en;
    logic        sin;
    logic        start;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic [15:0] shiftreg;
    logic        sout;

    int n_checks = 0;
    int n_fails  = 0;

    shift_reg_burst #(.WIDTH(16), .CNT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .sel      (sel),
        .en       (en),
        .sin      (sin),
        .start    (start),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .shiftreg (shiftreg),
        .sout     (sout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        data = v;
        tick();
        load = 1'b0;
    endtask

    // Fixed 40-cycle observation window bounds every burst; sel/count are disturbed to prove they are latched
    task automatic run_burst(input logic [2:0] m, input logic [4:0] n, input logic s,
                             output int busy_cyc, output int done_cnt, output int done_at);
        sel   = m;
        count = n;
        sin   = s;
        start = 1'b1;
        tick();
        start    = 1'b0;
        sel      = 3'b001;
        count    = 5'd31;
        busy_cyc = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
    endtask

    int bc, dc, da;
    int dcount;

    initial begin
        reset = 1'b1; load = 1'b0; data = '0; sel = 3'b000; en = 1'b0;
        sin = 1'b0; start = 1'b0; count = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_shiftreg", 32'(shiftreg), 32'h0);
        check("reset_busy",     32'(busy),     32'h0);
        check("reset_done",     32'(done),     32'h0);
        check("reset_sout",     32'(sout),     32'h0);

        do_load(16'hA5C3);
        check("load_value", 32'(shiftreg), 32'hA5C3);
        check("load_busy",  32'(busy),     32'h0);
        check("load_sout",  32'(sout),     32'h0);

        do_load(16'h8001);
        sel = 3'b001; sin = 1'b1; en = 1'b1;
        tick();
        en = 1'b0;
        check("shl_value", 32'(shiftreg), 32'h0003);
        check("shl_sout",  32'(sout),     32'h1);

        sel = 3'b110; en = 1'b1;
        tick();
        en = 1'b0;
        check("hold_value", 32'(shiftreg), 32'h0003);
        check("hold_sout",  32'(sout),     32'h1);

        do_load(16'h8000);
        sel = 3'b011; en = 1'b1;
        tick();
        en = 1'b0;
        check("asr_value", 32'(shiftreg), 32'hC000);
        check("asr_sout",  32'(sout),     32'h0);

        do_load(16'h00F0);
        run_burst(3'b010, 5'd4, 1'b0, bc, dc, da);
        check("shr4_value",   32'(shiftreg), 32'h000F);
        check("shr4_sout",    32'(sout),     32'h0);
        check("shr4_busycyc", 32'(bc),       32'd5);
        check("shr4_donecnt", 32'(dc),       32'd1);
        check("shr4_doneat",  32'(da),       32'd5);

        do_load(16'h8001);
        run_burst(3'b100, 5'd20, 1'b0, bc, dc, da);
`ifdef SHIFT_REG_ROTATE_EN
        check("rotl20_value", 32'(shiftreg), 32'h0018);
`else
        check("rotl20_value", 32'(shiftreg), 32'h8001);
`endif
        check("rotl20_busycyc", 32'(bc), 32'd21);
        check("rotl20_donecnt", 32'(dc), 32'd1);
        check("rotl20_doneat",  32'(da), 32'd21);

        do_load(16'h5A5A);
        run_burst(3'b001, 5'd0, 1'b1, bc, dc, da);
        check("cnt0_value",   32'(shiftreg), 32'h5A5A);
        check("cnt0_busycyc", 32'(bc),       32'd1);
        check("cnt0_donecnt", 32'(dc),       32'd1);
        check("cnt0_doneat",  32'(da),       32'd1);

        sel = 3'b001; count = 5'd3; data = 16'h00AA; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldstart_value", 32'(shiftreg), 32'h00AA);
        check("ldstart_busy",  32'(busy),     32'h0);

        do_load(16'hFFFF);
        sel = 3'b001; count = 5'd10; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_mid_value", 32'(shiftreg), 32'hFFFC);
        check("abort_mid_sout",  32'(sout),     32'h1);
        data = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        check("abort_value", 32'(shiftreg), 32'h1234);
        check("abort_busy",  32'(busy),     32'h0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_nodone", 32'(dcount),   32'd0);
        check("abort_hold",   32'(shiftreg), 32'h1234);

        do_load(16'hFFFF);
        sel = 3'b001; count = 5'd10; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rst_mid_busy", 32'(busy), 32'h1);
        check("rst_mid_sout", 32'(sout), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_value", 32'(shiftreg), 32'h0);
        check("rst_sout",  32'(sout),     32'h0);
        check("rst_busy",  32'(busy),     32'h0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dcount++;
            tick();
        end
        check("rst_nodone", 32'(dcount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_reg_burst.md
# shift_reg_burst

Parametrised successor to the 5-bit shift register in the voltage-monitor datapath. Provides a WIDTH-bit universal shift register with parallel load, serial in/out, logical, arithmetic and (optionally) rotate modes. Adds a burst engine that performs a programmed number of shifts under a start/busy/done handshake. It is used to serialise and align ADC/monitor words before they reach downstream logic.

## Interface
Parameters:
- WIDTH, 16, register width; legal range is 2 or more.
- CNT_W, 5, width of the burst count port.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  parallel load of `data`.
- data  in  WIDTH  parallel load value.
- sel  in  3  shift mode (see Operation).
- en  in  1  single-step enable while idle.
- sin  in  1  serial input bit.
- start  in  1  begin a burst of `count` shifts.
- count  in  CNT_W  number of shifts in a burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- shiftreg  out  WIDTH  register contents.
- sout  out  1  last bit shifted out.

## Operation
Mode encoding (`sel`):
- 000: hold.
- 001: SHL. `sin` enters the LSB; `sout` takes the old MSB.
- 010: SHR logical. `sin` enters the MSB; `sout` takes the old LSB.
- 011: ASR. The MSB is replicated; `sout` takes the old LSB.
- 100: ROTL. `sout` takes the old MSB.
- 101: ROTR. `sout` takes the old LSB.
- 110 and 111: hold.
- Any hold: `shiftreg` and `sout` are unchanged.

FSM states:
- IDLE
  - Priority per edge is reset > load > start > en.
  - `load`: shiftreg = data.
  - `start`: latch `sel` into mode_q and `count` into rem_q, then go to BURST.
  - `en`: one shift per `sel`.
- BURST
  - If rem_q > 0: shift per mode_q, then rem_q decrements.
  - If rem_q == 0: go to IDLE and pulse `done`.

Boundary rules:
- `load` during BURST aborts the burst. Data is loaded, the FSM returns to IDLE, and `done` is not pulsed.
- `start` while busy is ignored. `en` is ignored while busy. Changes to `sel` or `count` during BURST are ignored.
- `count` = 0: no shift occurs; busy is high for 1 cycle, then `done` pulses.
- `count` greater than WIDTH is legal; shifting continues, so SHL/SHR fill entirely with `sin`.
- Simultaneous `load` and `start` in IDLE: the load wins and the start is dropped.
- `reset` mid-burst: the FSM returns to IDLE immediately and `done` is not pulsed.

Reset values:
- shiftreg = 0
- sout = 0
- busy = 0
- done = 0
- FSM = IDLE
- rem_q = 0
- mode_q = hold

## Timing
- `load` or `en` step: the result is visible the cycle after the sampling edge (1-cycle latency).
- Burst with `start` sampled at edge k and `count` = N:
  - busy = 1 after edges k through k+N.
  - Shifts occur at edges k+1 through k+N.
  - busy = 0 and done = 1 after edge k+N+1, for exactly one cycle.
  - Total start-to-done time is N+1 cycles.
- `start` can be accepted in the same cycle `done` is high, since the FSM is already IDLE.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SHIFT_REG_ROTATE_EN defined: modes 100 and 101 rotate as specified.
- Undefined: 100 and 101 decode as hold. A burst with a rotate mode still runs its full count and pulses `done`, but contents and `sout` stay unchanged.

## Structure
- Package `shift_pkg`:
  - `shift_mode_e`, a 3-bit enum of the encodings above.
  - `burst_state_e` (IDLE, BURST).
  - Mode constants.
- Sub-module `shift_step_unit`: combinational next-value logic.
  - Inputs: WIDTH-bit value, mode, `sin`.
  - Outputs: next value, out bit.
  - Shared by the step path and the burst path.
  - Rotate decode is gated by SHIFT_REG_ROTATE_EN inside this unit.
- The top level holds the registers, the FSM and the remaining-count counter.

## Test plan
All scenarios use WIDTH=16.
- Reset, then load 16'hA5C3 → shiftreg=16'hA5C3 next cycle; busy=0, done=0, sout=0.
- Load 16'h8001; `en`=1, sel=001, sin=1, for 1 cycle → shiftreg=16'h0003, sout=1. Then one ASR step from 16'h8000 → 16'hC000, sout=0.
- Load 16'h00F0; start with sel=010, count=4, sin=0 → busy for 5 cycles, shiftreg=16'h000F, done pulses exactly once, sout=0.
- With the macro: load 16'h8001, start ROTL with count=20 → 16'h0018 (rotate by 4). Without the macro: contents stay 16'h8001 and `done` still pulses after 21 cycles.
- Start count=0 → busy for one cycle, then `done`; shiftreg unchanged.
- Start SHL count=10, assert `load` of 16'h1234 at the third burst cycle → shiftreg=16'h1234, busy=0, no `done` pulse. Repeat with `reset` instead → all outputs return to 0.
